zigzag_buf_ctrl: RTL

Ping-pong reorder controller for the fdct_zigzag stage of jpeg_encoder. It accepts 64 DCT coefficients per 8x8 block in raster order and stores them in one of two internal banks. Once a bank is full, it streams that bank out in JPEG zigzag order. Writing of the next block overlaps with reading of the current one. It replaces the shift-register sresult array with sequenced, handshaked storage.

---
 rtl/zigzag_buf_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/zigzag_buf_ctrl.sv
// Ping-pong 8x8 coefficient buffer: raster-order writes into one bank while the
// other bank is streamed out in JPEG zigzag order with valid/ready handshakes.
module zigzag_buf_ctrl #(
    parameter int DW  = 12,
    parameter int BLK = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          clr,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_sob,
    output logic          dout_eob,
    output logic          busy
);

    localparam int AW = $clog2(BLK);
    localparam logic [AW-1:0] LAST = AW'(BLK - 1);

    // Zigzag index -> raster address
    localparam logic [5:0] ZZ_ROM [0:63] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic          wr_bank_reg, wr_bank_next;
    logic          rd_bank_reg, rd_bank_next;
    logic [AW-1:0] wr_cnt_reg, wr_cnt_next;
    logic [AW-1:0] rd_cnt_reg, rd_cnt_next;
    logic [1:0]    full_reg, full_next;
    logic [1:0]    set_full, drop_full;
    logic          wr_fire, rd_fire;
    logic [AW:0]   rd_addr;

    logic [DW-1:0] mem [0:2*BLK-1];

    assign din_ready  = ~full_reg[wr_bank_reg];
    assign dout_valid = full_reg[rd_bank_reg];
    assign wr_fire    = ena & din_valid & din_ready;
    assign rd_fire    = ena & dout_valid & dout_ready;

    assign rd_addr    = {rd_bank_reg, ZZ_ROM[rd_cnt_reg]};
    assign dout       = mem[rd_addr];
    assign dout_sob   = dout_valid & (rd_cnt_reg == '0);
    assign dout_eob   = dout_valid & (rd_cnt_reg == LAST);
    assign busy       = (|full_reg) | (wr_cnt_reg != '0);

    // A bank only fills while empty and only drains while full, so the set and
    // drop terms never target the same bank in one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign set_full[gi]  = wr_fire & (wr_cnt_reg == LAST) & (wr_bank_reg == 1'(gi));
            assign drop_full[gi] = rd_fire & (rd_cnt_reg == LAST) & (rd_bank_reg == 1'(gi));
            assign full_next[gi] = ~clr & ((full_reg[gi] | set_full[gi]) & ~drop_full[gi]);
        end
    endgenerate

    always_comb begin
        wr_bank_next = wr_bank_reg;
        rd_bank_next = rd_bank_reg;
        wr_cnt_next  = wr_cnt_reg;
        rd_cnt_next  = rd_cnt_reg;
        if (wr_fire) begin
            if (wr_cnt_reg == LAST) begin
                wr_cnt_next  = '0;
                wr_bank_next = ~wr_bank_reg;
            end else begin
                wr_cnt_next = wr_cnt_reg + AW'(1);
            end
        end
        if (rd_fire) begin
            if (rd_cnt_reg == LAST) begin
                rd_cnt_next  = '0;
                rd_bank_next = ~rd_bank_reg;
            end else begin
                rd_cnt_next = rd_cnt_reg + AW'(1);
            end
        end
        if (clr) begin
            wr_bank_next = 1'b0;
            rd_bank_next = 1'b0;
            wr_cnt_next  = '0;
            rd_cnt_next  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_reg <= 1'b0;
            rd_bank_reg <= 1'b0;
            wr_cnt_reg  <= '0;
            rd_cnt_reg  <= '0;
            full_reg    <= '0;
        end else if (ena) begin
            wr_bank_reg <= wr_bank_next;
            rd_bank_reg <= rd_bank_next;
            wr_cnt_reg  <= wr_cnt_next;
            rd_cnt_reg  <= rd_cnt_next;
            full_reg    <= full_next;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_fire && rst && !clr) begin
            mem[{wr_bank_reg, wr_cnt_reg}] <= din;
        end
    end

endmodule
